// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue
// Purpose  : In-order circular buffer between rename and the issue queue.
//            Accepts up to IN_WIDTH renamed instructions per cycle and
//            presents the OUT_WIDTH oldest entries combinationally.
// Ports    : clk, rst_n (sync, active-low), flush (empties the queue)
//            enq_*  : per-lane enqueue (lanes contiguous from lane 0)
//            full   : fewer than IN_WIDTH free slots (registered state only)
//            deq_*  : lane j shows the j-th oldest entry; deq_num retires
//            wb_*   : writeback wakeup broadcast
//            count  : occupied entries
// Option   : DISPATCH_QUEUE_WAKEUP_EN - snoop wb_tag to set operand-ready bits
//            (stored and bypassed to deq_*_valid). Undefined: wb_* ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int IN_WIDTH      = 2,
    parameter int OUT_WIDTH     = 2,
    parameter int DEPTH         = 8,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int WB_PORTS      = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               enq_en        [0:IN_WIDTH-1],
    input  logic [TAG_WIDTH-1:0]               enq_op1       [0:IN_WIDTH-1],
    input  logic [TAG_WIDTH-1:0]               enq_op2       [0:IN_WIDTH-1],
    input  logic                               enq_op1_valid [0:IN_WIDTH-1],
    input  logic                               enq_op2_valid [0:IN_WIDTH-1],
    input  logic [PAYLOAD_WIDTH-1:0]           enq_payload   [0:IN_WIDTH-1],
    output logic                               full,
    output logic                               deq_valid     [0:OUT_WIDTH-1],
    output logic [TAG_WIDTH-1:0]               deq_op1       [0:OUT_WIDTH-1],
    output logic [TAG_WIDTH-1:0]               deq_op2       [0:OUT_WIDTH-1],
    output logic                               deq_op1_valid [0:OUT_WIDTH-1],
    output logic                               deq_op2_valid [0:OUT_WIDTH-1],
    output logic [PAYLOAD_WIDTH-1:0]           deq_payload   [0:OUT_WIDTH-1],
    input  logic [$clog2(OUT_WIDTH+1)-1:0]     deq_num,
    input  logic                               wb_en         [0:WB_PORTS-1],
    input  logic [TAG_WIDTH-1:0]               wb_tag        [0:WB_PORTS-1],
    output logic [$clog2(DEPTH+1)-1:0]         count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    // full when free slots (DEPTH - count) < IN_WIDTH, i.e. count > DEPTH - IN_WIDTH
    localparam logic [c_cnt_w-1:0] c_full_thresh = c_cnt_w'(DEPTH - IN_WIDTH);

    logic [c_ptr_w-1:0]       r_head;
    logic [c_ptr_w-1:0]       r_tail;
    logic [c_cnt_w-1:0]       r_count;
    logic [TAG_WIDTH-1:0]     r_op1     [DEPTH];
    logic [TAG_WIDTH-1:0]     r_op2     [DEPTH];
    logic                     r_op1_v   [DEPTH];
    logic                     r_op2_v   [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] r_payload [DEPTH];

    logic                     w_enq_fire;
    logic [c_cnt_w-1:0]       w_enq_k;
    logic                     w_enq_gap;
    logic                     w_wake_op1     [DEPTH];
    logic                     w_wake_op2     [DEPTH];
    logic                     w_enq_wake_op1 [IN_WIDTH];
    logic                     w_enq_wake_op2 [IN_WIDTH];
    logic [c_ptr_w-1:0]       w_deq_idx      [OUT_WIDTH];

    assign full       = r_count > c_full_thresh;
    assign count      = r_count;
    assign w_enq_fire = !full && !flush;

    // Lane count actually written this cycle (zero when blocked).
    always_comb begin
        w_enq_k   = '0;
        w_enq_gap = 1'b0;
        for (int l = 0; l < IN_WIDTH; l++) begin
            if (enq_en[l]) w_enq_k = w_enq_k + c_cnt_w'(1);
        end
        for (int l = 1; l < IN_WIDTH; l++) begin
            if (enq_en[l] && !enq_en[l-1]) w_enq_gap = 1'b1;
        end
        if (!w_enq_fire) w_enq_k = '0;
    end

`ifdef DISPATCH_QUEUE_WAKEUP_EN
    // Tag match against every broadcast port, for resident slots and incoming lanes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake_op1[i] = 1'b0;
            w_wake_op2[i] = 1'b0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_en[p] && (wb_tag[p] == r_op1[i])) w_wake_op1[i] = 1'b1;
                if (wb_en[p] && (wb_tag[p] == r_op2[i])) w_wake_op2[i] = 1'b1;
            end
        end
        for (int l = 0; l < IN_WIDTH; l++) begin
            w_enq_wake_op1[l] = 1'b0;
            w_enq_wake_op2[l] = 1'b0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_en[p] && (wb_tag[p] == enq_op1[l])) w_enq_wake_op1[l] = 1'b1;
                if (wb_en[p] && (wb_tag[p] == enq_op2[l])) w_enq_wake_op2[l] = 1'b1;
            end
        end
    end
`else
    logic w_unused_wb;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake_op1[i] = 1'b0;
            w_wake_op2[i] = 1'b0;
        end
        for (int l = 0; l < IN_WIDTH; l++) begin
            w_enq_wake_op1[l] = 1'b0;
            w_enq_wake_op2[l] = 1'b0;
        end
        w_unused_wb = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            w_unused_wb = w_unused_wb ^ wb_en[p] ^ (^wb_tag[p]);
        end
    end
`endif

    // Entry storage needs no reset: occupancy is tracked by head/tail/count.
    // Wakeup is applied first so a same-cycle enqueue into a slot wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_op1_v[i] <= r_op1_v[i] | w_wake_op1[i];
            r_op2_v[i] <= r_op2_v[i] | w_wake_op2[i];
        end
        for (int l = 0; l < IN_WIDTH; l++) begin
            if (w_enq_fire && enq_en[l]) begin
                r_op1[r_tail + c_ptr_w'(l)]     <= enq_op1[l];
                r_op2[r_tail + c_ptr_w'(l)]     <= enq_op2[l];
                r_op1_v[r_tail + c_ptr_w'(l)]   <= enq_op1_valid[l] | w_enq_wake_op1[l];
                r_op2_v[r_tail + c_ptr_w'(l)]   <= enq_op2_valid[l] | w_enq_wake_op2[l];
                r_payload[r_tail + c_ptr_w'(l)] <= enq_payload[l];
            end
        end
    end

    // Pointers and occupancy; flush has priority over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_ptr_w'(deq_num);
            r_tail  <= r_tail + c_ptr_w'(w_enq_k);
            r_count <= r_count + w_enq_k - c_cnt_w'(deq_num);
        end
    end

    for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_deq_lane
        assign w_deq_idx[j]     = r_head + c_ptr_w'(j);
        assign deq_valid[j]     = c_cnt_w'(j) < r_count;
        assign deq_op1[j]       = r_op1[w_deq_idx[j]];
        assign deq_op2[j]       = r_op2[w_deq_idx[j]];
        assign deq_op1_valid[j] = r_op1_v[w_deq_idx[j]] | w_wake_op1[w_deq_idx[j]];
        assign deq_op2_valid[j] = r_op2_v[w_deq_idx[j]] | w_wake_op2[w_deq_idx[j]];
        assign deq_payload[j]   = r_payload[w_deq_idx[j]];
    end

    a_enq_contiguous: assert property (@(posedge clk) disable iff (!rst_n) !w_enq_gap);
    a_deq_in_range:   assert property (@(posedge clk) disable iff (!rst_n || flush)
                                       c_cnt_w'(deq_num) <= r_count);

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_queue
// Purpose  : Directed self-checking bench for dispatch_queue (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;

`ifdef DISPATCH_QUEUE_WAKEUP_EN
    localparam logic c_wake = 1'b1;
`else
    localparam logic c_wake = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         enq_en        [0:1];
    logic [5:0]   enq_op1       [0:1];
    logic [5:0]   enq_op2       [0:1];
    logic         enq_op1_valid [0:1];
    logic         enq_op2_valid [0:1];
    logic [127:0] enq_payload   [0:1];
    logic         full;
    logic         deq_valid     [0:1];
    logic [5:0]   deq_op1       [0:1];
    logic [5:0]   deq_op2       [0:1];
    logic         deq_op1_valid [0:1];
    logic         deq_op2_valid [0:1];
    logic [127:0] deq_payload   [0:1];
    logic [1:0]   deq_num;
    logic         wb_en         [0:1];
    logic [5:0]   wb_tag        [0:1];
    logic [3:0]   count;

    int total = 0;
    int bad   = 0;

    dispatch_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_en(enq_en), .enq_op1(enq_op1), .enq_op2(enq_op2),
        .enq_op1_valid(enq_op1_valid), .enq_op2_valid(enq_op2_valid),
        .enq_payload(enq_payload), .full(full), .deq_valid(deq_valid),
        .deq_op1(deq_op1), .deq_op2(deq_op2),
        .deq_op1_valid(deq_op1_valid), .deq_op2_valid(deq_op2_valid),
        .deq_payload(deq_payload), .deq_num(deq_num),
        .wb_en(wb_en), .wb_tag(wb_tag), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush   = 1'b0;
        deq_num = 2'd0;
        for (int l = 0; l < 2; l++) begin
            enq_en[l]        = 1'b0;
            enq_op1[l]       = 6'd0;
            enq_op2[l]       = 6'd0;
            enq_op1_valid[l] = 1'b1;
            enq_op2_valid[l] = 1'b0;
            enq_payload[l]   = '0;
            wb_en[l]         = 1'b0;
            wb_tag[l]        = 6'd0;
        end
    endtask

    task automatic enq(input int n, input logic [127:0] a, input logic [127:0] b);
        enq_en[0]      = (n > 0);
        enq_en[1]      = (n > 1);
        enq_payload[0] = a;
        enq_payload[1] = b;
        enq_op1[0]     = a[5:0];
        enq_op1[1]     = b[5:0];
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("reset_count", 128'(count), 128'd0);
        chk("reset_full", 128'(full), 128'd0);
        chk("reset_valid0", 128'(deq_valid[0]), 128'd0);
        chk("reset_valid1", 128'(deq_valid[1]), 128'd0);
        rst_n = 1'b1;

        // First pair, visible after one edge
        enq(2, 128'hA, 128'hB);
        tick(); idle();
        chk("first_count", 128'(count), 128'd2);
        chk("first_valid0", 128'(deq_valid[0]), 128'd1);
        chk("first_valid1", 128'(deq_valid[1]), 128'd1);
        chk("first_pay0", deq_payload[0], 128'hA);
        chk("first_pay1", deq_payload[1], 128'hB);
        chk("first_op1v", 128'(deq_op1_valid[0]), 128'd1);
        chk("first_op2v", 128'(deq_op2_valid[0]), 128'd0);

        // Fill to DEPTH
        enq(2, 128'hC, 128'hD); tick(); idle();
        chk("fill4_count", 128'(count), 128'd4);
        chk("fill4_full", 128'(full), 128'd0);
        enq(2, 128'hE, 128'hF); tick(); idle();
        chk("fill6_count", 128'(count), 128'd6);
        chk("fill6_full", 128'(full), 128'd0);
        enq(2, 128'h10, 128'h11); tick(); idle();
        chk("fill8_count", 128'(count), 128'd8);
        chk("fill8_full", 128'(full), 128'd1);
        enq(2, 128'h99, 128'h9A); tick(); idle();
        chk("over_count", 128'(count), 128'd8);
        chk("over_pay0", deq_payload[0], 128'hA);
        chk("over_pay1", deq_payload[1], 128'hB);

        // Drain, checking full at count 7
        deq_num = 2'd1; tick(); idle();
        chk("c7_count", 128'(count), 128'd7);
        chk("c7_full", 128'(full), 128'd1);
        chk("c7_pay0", deq_payload[0], 128'hB);
        deq_num = 2'd2; tick(); idle();
        chk("c5_pay0", deq_payload[0], 128'hD);
        chk("c5_full", 128'(full), 128'd0);
        deq_num = 2'd2; tick(); idle();
        chk("c3_pay0", deq_payload[0], 128'hF);
        deq_num = 2'd2; tick(); idle();
        chk("c1_pay0", deq_payload[0], 128'h11);
        chk("c1_valid1", 128'(deq_valid[1]), 128'd0);
        deq_num = 2'd1; tick(); idle();
        chk("empty_count", 128'(count), 128'd0);

        // Three rounds of enq 2 / deq 2 move pointers to slot 6
        for (int r = 0; r < 3; r++) begin
            enq(2, 128'h50, 128'h51); tick(); idle();
            deq_num = 2'd2; tick(); idle();
        end
        enq(2, 128'h1, 128'h2); tick(); idle();
        enq(2, 128'h3, 128'h4); tick(); idle();
        chk("wrap_count", 128'(count), 128'd4);
        chk("wrap_pay0", deq_payload[0], 128'h1);
        chk("wrap_pay1", deq_payload[1], 128'h2);
        deq_num = 2'd2; tick(); idle();
        chk("wrap2_pay0", deq_payload[0], 128'h3);
        chk("wrap2_pay1", deq_payload[1], 128'h4);

        // Simultaneous enqueue and dequeue
        enq(2, 128'h5, 128'h6); tick(); idle();
        chk("sim_pre_count", 128'(count), 128'd4);
        enq(2, 128'h7, 128'h8); deq_num = 2'd1; tick(); idle();
        chk("sim_count", 128'(count), 128'd5);
        chk("sim_pay0", deq_payload[0], 128'h4);
        chk("sim_pay1", deq_payload[1], 128'h5);
        enq(2, 128'h9, 128'h1A); deq_num = 2'd1; tick(); idle();
        chk("pre_flush_count", 128'(count), 128'd6);

        // Flush overrides enqueue and dequeue
        enq(2, 128'h77, 128'h78); deq_num = 2'd2; flush = 1'b1; tick(); idle();
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_valid0", 128'(deq_valid[0]), 128'd0);
        chk("flush_valid1", 128'(deq_valid[1]), 128'd0);
        chk("flush_full", 128'(full), 128'd0);
        enq(2, 128'h21, 128'h22); tick(); idle();
        chk("post_flush_pay0", deq_payload[0], 128'h21);
        chk("post_flush_count", 128'(count), 128'd2);

        // Reset in mid-operation
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_count", 128'(count), 128'd0);
        chk("midrst_valid0", 128'(deq_valid[0]), 128'd0);

        // Wakeup of a resident entry
        enq(1, 128'h30, 128'h0); enq_op1[0] = 6'd5; enq_op1_valid[0] = 1'b0;
        tick(); idle();
        chk("wake_op1", 128'(deq_op1[0]), 128'd5);
        chk("wake_before", 128'(deq_op1_valid[0]), 128'd0);
        wb_en[0] = 1'b1; wb_tag[0] = 6'd4; #1;
        chk("wake_wrongtag", 128'(deq_op1_valid[0]), 128'd0);
        wb_en[0] = 1'b0; wb_en[1] = 1'b1; wb_tag[1] = 6'd5; #1;
        chk("wake_bypass", 128'(deq_op1_valid[0]), 128'(c_wake));
        tick(); idle(); #1;
        chk("wake_sticky", 128'(deq_op1_valid[0]), 128'(c_wake));

        // Wakeup coincident with enqueue
        enq(1, 128'h31, 128'h0); enq_op1[0] = 6'd7; enq_op1_valid[0] = 1'b0;
        wb_en[0] = 1'b1; wb_tag[0] = 6'd7;
        tick(); idle();
        chk("wake_enq_valid1", 128'(deq_valid[1]), 128'd1);
        chk("wake_enq_pay1", deq_payload[1], 128'h31);
        chk("wake_enq_op1v", 128'(deq_op1_valid[1]), 128'(c_wake));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised in-order buffer between the rename unit and the issue queue.
- Accepts up to IN_WIDTH renamed instructions per cycle and presents the oldest OUT_WIDTH entries to the issue queue.
- Decouples rename from issue-queue back-pressure.
- Snoops writeback tags so operand-ready bits stay current while entries wait.

Parameters:
- IN_WIDTH, 2: enqueue lanes per cycle (equals DISPATCH_WIDTH at top level).
- OUT_WIDTH, 2: dequeue lanes per cycle.
- DEPTH, 8: entries; power of two, DEPTH >= max(IN_WIDTH, OUT_WIDTH).
- TAG_WIDTH, 6: physical register tag width (PHYS_REGS_ADDR_WIDTH).
- PAYLOAD_WIDTH, 128: opaque packed fields carried unchanged (alu_cmd, op2, op2_type, phys_rd, bank_addr, rob_addr, pc, instr, is_branch_instr).
- WB_PORTS, 2: writeback wakeup broadcast ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all entries (branch mispredict).
- enq_en  in  [0:IN_WIDTH-1] x1  lane valid; must be contiguous from lane 0.
- enq_op1  in  [0:IN_WIDTH-1] xTAG_WIDTH  op1 tag.
- enq_op2  in  [0:IN_WIDTH-1] xTAG_WIDTH  op2 tag (meaningful only when op2 is a register).
- enq_op1_valid, enq_op2_valid  in  [0:IN_WIDTH-1] x1  operand ready.
- enq_payload  in  [0:IN_WIDTH-1] xPAYLOAD_WIDTH  payload.
- full  out  1  cannot accept IN_WIDTH entries this cycle.
- deq_valid  out  [0:OUT_WIDTH-1] x1  slot j holds the j-th oldest entry.
- deq_op1, deq_op2, deq_op1_valid, deq_op2_valid, deq_payload  out  per lane  entry fields.
- deq_num  in  $clog2(OUT_WIDTH+1)  number of oldest entries consumed this cycle.
- wb_en  in  [0:WB_PORTS-1] x1  wakeup valid.
- wb_tag  in  [0:WB_PORTS-1] xTAG_WIDTH  woken tag.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`.
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a registered `count`.
- Reset (rst_n=0 at posedge):
  - head=tail=count=0, all entry valid bits cleared.
  - Outputs: full=0, deq_valid all 0, count=0.
  - Reset mid-operation discards all contents.
- full:
  - full = (DEPTH - count) < IN_WIDTH.
  - Derived from registered state only; independent of the same-cycle deq_num.
- Enqueue:
  - When !full and !flush, the k asserted lanes (k = popcount of enq_en) are written to tail..tail+k-1 in lane order, and tail advances by k.
  - When full=1, enq_en is ignored with no state change; the producer holds its inputs.
  - Non-contiguous enq_en is illegal and is caught by an assertion.
- Dequeue:
  - deq_valid[j] = (j < count).
  - Lane j presents entry (head+j) mod DEPTH, combinationally from state.
  - deq_num entries retire at the clock edge and head advances by deq_num.
  - deq_num > count is illegal and is caught by an assertion.
- Simultaneous enqueue and dequeue: count_next = count + k - deq_num. Dequeued slots are not reusable by the same-cycle enqueue.
- flush: highest priority. The next state is empty (head=tail=count=0), ignoring enq_en, deq_num and wakeups.
- Latency:
  - An entry enqueued at edge N is visible on deq lanes after edge N.
  - No same-cycle bypass from enqueue to dequeue; minimum latency is 1 cycle.
- Wrap-around:
  - Pointer arithmetic wraps modulo DEPTH.
  - Full at count==DEPTH; empty at count==0.

Optional Feature:
- Macro: DISPATCH_QUEUE_WAKEUP_EN.
- Defined:
  - Every cycle, each resident entry sets op1_valid (op2_valid) when any wb_en[p] with wb_tag[p]==op1 (op2).
  - Entries being enqueued in the same cycle are also matched, so the stored valid = enq_*_valid | match.
  - deq_*_valid outputs are bypassed: stored | same-cycle match.
  - Valid bits never clear except by dequeue, flush or reset.
- Undefined: wb_* ports remain but are ignored; operand valid bits are stored and presented exactly as enqueued.

Test Plan:
- Reset then enq_en={1,1} with payloads 0xA, 0xB -> after 1 edge count=2, deq_valid={1,1}, deq_payload={0xA,0xB}.
- Fill: DEPTH=8, IN_WIDTH=2, enqueue 2/cycle with deq_num=0 -> count=2,4,6,8; full=1 when count=7 or 8; a further enq at count=8 leaves count=8 and contents unchanged.
- Wrap: after 3 rounds of enq 2 / deq 2, head=tail=6; enqueue 0x1..0x4 over two cycles -> entries in slots 6,7,0,1; dequeue order 0x1,0x2,0x3,0x4.
- Simultaneous events: count=4, enq k=2, deq_num=1 -> count=5; the oldest of the remaining entries is presented on lane 0.
- Flush asserted with enq_en={1,1}, deq_num=2, count=6 -> next cycle count=0, deq_valid all 0, full=0.
- Wakeup (with DISPATCH_QUEUE_WAKEUP_EN): entry op1=5, op1_valid=0; wb_en[1]=1, wb_tag[1]=5 -> deq_op1_valid=1 in the same cycle and stays 1 afterwards. Repeat with the wakeup coincident with enqueue -> stored valid=1. Without the macro -> deq_op1_valid stays 0.
